// File: rtl/seq_muldiv_unit.sv
// rtl/seq_muldiv_unit.sv - iterative signed/unsigned multiply/divide unit with HI/LO result pair
//
// Purpose:
//   Fixed-latency shift-add multiplier and restoring divider sharing one
//   accumulator/shift-register pair. The caller pulses start, waits for done,
//   then reads hi/lo. Operands are converted to magnitudes on entry; the sign
//   is reapplied in the FIX cycle.
//
// Configuration:
//   MULDIV_DIV_EN - when defined, the divider datapath is built and ops 10/11
//                   divide. When undefined, DIV/DIVU finish two edges after
//                   start with hi=lo=0 and div_by_zero=0.
//
// Ports:
//   Clock        in   system clock, rising edge
//   clear        in   asynchronous active-high reset
//   start        in   request, sampled only in IDLE
//   op[1:0]      in   00 MUL, 01 MULU, 10 DIV, 11 DIVU
//   a[WIDTH-1:0] in   multiplicand / dividend
//   b[WIDTH-1:0] in   multiplier / divisor
//   busy         out  operation in progress (RUN or FIX)
//   done         out  one-cycle pulse, hi/lo valid from this cycle
//   hi           out  product upper half / remainder
//   lo           out  product lower half / quotient
//   div_by_zero  out  last accepted divide had b==0

module seq_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_neg_q;   // product / quotient must be negated
  logic [WIDTH:0]     r_acc;     // partial product high half / partial remainder
  logic [WIDTH-1:0]   r_mq;      // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0]   r_b;       // multiplicand / divisor magnitude
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_dbz;

  // Operand preparation: ops with op[0]==0 are the signed variants.
  logic               w_signed;
  logic               w_is_div;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_skip_run;

  assign w_signed = ~op[0];
  assign w_is_div = op[1];
  assign w_a_neg  = w_signed & a[WIDTH-1];
  assign w_b_neg  = w_signed & b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;

  // Multiply step: add multiplicand when the current multiplier bit is set,
  // then shift {acc, mq} right by one so the product forms in place.
  logic [WIDTH:0]     w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;

  assign w_addend = r_mq[0] ? {1'b0, r_b} : '0;
  assign w_sum    = r_acc + w_addend;
  assign w_prod   = {r_acc[WIDTH-1:0], r_mq};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;

`ifdef MULDIV_DIV_EN
  logic               r_neg_r;   // remainder follows the dividend sign
  logic               r_zdiv;    // divide by zero: r_acc holds raw a
  logic               w_b_zero;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH+1:0]   w_diff;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  assign w_b_zero   = (b == '0);
  assign w_skip_run = w_is_div & w_b_zero;
  // Restoring step: bring the next dividend bit into the remainder and
  // keep the subtraction only if it did not borrow.
  assign w_shift    = {r_acc[WIDTH-1:0], r_mq[WIDTH-1]};
  assign w_diff     = {1'b0, w_shift} - {2'b00, r_b};
  assign w_quot     = r_neg_q ? -r_mq : r_mq;
  assign w_rem      = r_neg_r ? -(r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
`else
  assign w_skip_run = w_is_div;
`endif

  // State register
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = w_skip_run ? S_FIX : S_RUN;
      S_RUN:   if (r_cnt == CNT_LAST) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_acc    <= '0;
      r_mq     <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_neg_r  <= 1'b0;
      r_zdiv   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt    <= '0;
            r_is_div <= w_is_div;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_mq     <= w_is_div ? w_a_mag : w_b_mag;
            r_b      <= w_is_div ? w_b_mag : w_a_mag;
            r_dbz    <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_neg_r  <= w_a_neg;
            r_zdiv   <= w_skip_run;
            r_acc    <= w_skip_run ? {1'b0, a} : '0;
`else
            r_acc    <= '0;
`endif
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + CW'(1);
`ifdef MULDIV_DIV_EN
          if (r_is_div) begin
            if (!w_diff[WIDTH+1]) begin
              r_acc <= w_diff[WIDTH:0];
              r_mq  <= {r_mq[WIDTH-2:0], 1'b1};
            end else begin
              r_acc <= w_shift;
              r_mq  <= {r_mq[WIDTH-2:0], 1'b0};
            end
          end else begin
            r_acc <= {1'b0, w_sum[WIDTH:1]};
            r_mq  <= {w_sum[0], r_mq[WIDTH-1:1]};
          end
`else
          r_acc <= {1'b0, w_sum[WIDTH:1]};
          r_mq  <= {w_sum[0], r_mq[WIDTH-1:1]};
`endif
        end
        S_FIX: begin
          r_done <= 1'b1;
          if (r_is_div) begin
`ifdef MULDIV_DIV_EN
            if (r_zdiv) begin
              r_hi  <= r_acc[WIDTH-1:0];
              r_lo  <= '1;
              r_dbz <= 1'b1;
            end else begin
              r_hi  <= w_rem;
              r_lo  <= w_quot;
            end
`else
            r_hi <= '0;
            r_lo <= '0;
`endif
          end else begin
            r_hi <= w_prod_s[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_s[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

endmodule
